// File: rtl/pipelined_array_multiplier.sv
// Pipelined WIDTH x WIDTH array multiplier, unsigned or Baugh-Wooley signed per operation.
// Partial-product rows are spread evenly over STAGES register stages behind a global stall.
module pam_rows #(
    parameter int WIDTH = 4,
    parameter int K     = 0,
    parameter int R     = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] sum
);
    localparam logic [2*WIDTH-1:0] ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    // Baugh-Wooley correction: +2^W and +2^(2W-1), folded in once at the first stage
    localparam logic [2*WIDTH-1:0] BW_K = (ONE << WIDTH) | (ONE << (2*WIDTH-1));

    logic [WIDTH-1:0] pp;

    always_comb begin
        sum = acc;
        pp  = '0;
        if (K == 0 && is_signed)
            sum = sum + BW_K;
        for (int r = 0; r < R; r++) begin
            pp = a & {WIDTH{b[K*R+r]}};
            if (is_signed) begin
                // cross terms with exactly one sign bit are complemented
                if (K*R + r == WIDTH-1)
                    pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
                else
                    pp[WIDTH-1] = ~pp[WIDTH-1];
            end
            sum = sum + ({{WIDTH{1'b0}}, pp} << (K*R + r));
        end
    end
endmodule

module pipelined_array_multiplier #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out
);
    localparam int R = WIDTH / STAGES;

    logic              adv;
    logic [STAGES-1:0] vld_pipe;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0]   op_a, op_b;
            logic               op_sgn;
            logic [2*WIDTH-1:0] op_sum, nxt_sum, sum_r;

            if (k == 0) begin : g_head
                assign op_a   = a;
                assign op_b   = b;
                assign op_sgn = is_signed;
                assign op_sum = '0;
            end else begin : g_link
                assign op_a   = g_stage[k-1].g_fwd.a_r;
                assign op_b   = g_stage[k-1].g_fwd.b_r;
                assign op_sgn = g_stage[k-1].g_fwd.sgn_r;
                assign op_sum = g_stage[k-1].sum_r;
            end

            pam_rows #(.WIDTH(WIDTH), .K(k), .R(R)) u_rows (
                .a        (op_a),
                .b        (op_b),
                .is_signed(op_sgn),
                .acc      (op_sum),
                .sum      (nxt_sum)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   sum_r <= '0;
                else if (adv) sum_r <= nxt_sum;
            end

            // operands only travel as far as the last stage that still needs them
            if (k < STAGES-1) begin : g_fwd
                logic [WIDTH-1:0] a_r, b_r;
                logic             sgn_r;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_r   <= '0;
                        b_r   <= '0;
                        sgn_r <= 1'b0;
                    end else if (adv) begin
                        a_r   <= op_a;
                        b_r   <= op_b;
                        sgn_r <= op_sgn;
                    end
                end
            end
        end
    endgenerate

    assign out = g_stage[STAGES-1].sum_r;
endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed-vector and scoreboard bench for pipelined_array_multiplier (4x4/2 plus 8-bit corners).
module tb_pipelined_array_multiplier;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_ready, is_signed = 1'b0, out_valid, out_ready = 1'b1;
    logic [3:0] a = '0, b = '0;
    logic [7:0] out;

    pipelined_array_multiplier #(.WIDTH(4), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .out(out)
    );

    // 8-bit instances for STAGES = 1, 4, 8 sharing one input stream
    localparam int ST8 [3] = '{1, 4, 8};
    logic        v8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  ir8, ov8;
    logic [15:0] o8 [3];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_wide
            pipelined_array_multiplier #(.WIDTH(8), .STAGES(ST8[g])) u_w (
                .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8[g]),
                .a(a8), .b(b8), .is_signed(sgn8), .out_valid(ov8[g]),
                .out_ready(1'b1), .out(o8[g])
            );
        end
    endgenerate

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [3:0] x, input logic [3:0] y, input logic s);
        int p;
        if (s) p = $signed(x) * $signed(y);
        else   p = x * y;
        return p[7:0];
    endfunction

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [12];

    logic [7:0] q [$];
    logic [7:0] front;
    int idx, cyc;
    logic took;

    initial begin
        tbl[0]  = '{4'd0,  4'd0,  1'b0, 8'h00};
        tbl[1]  = '{4'd4,  4'd2,  1'b0, 8'h08};
        tbl[2]  = '{4'd5,  4'd6,  1'b0, 8'h1E};
        tbl[3]  = '{4'd15, 4'd15, 1'b0, 8'hE1};
        tbl[4]  = '{4'h5,  4'hE,  1'b1, 8'hF6};
        tbl[5]  = '{4'h7,  4'h8,  1'b1, 8'hC8};
        tbl[6]  = '{4'h8,  4'h8,  1'b1, 8'h40};
        tbl[7]  = '{4'hF,  4'hF,  1'b1, 8'h01};
        tbl[8]  = '{4'h5,  4'hE,  1'b0, 8'h46};
        tbl[9]  = '{4'h7,  4'h8,  1'b0, 8'h38};
        tbl[10] = '{4'h7,  4'h7,  1'b1, 8'h31};
        tbl[11] = '{4'h3,  4'hF,  1'b1, 8'hFD};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_out", 16'(out), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        rst_n = 1'b1;

        // back-to-back table sweep, latency 2
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("sweep_valid", 16'(out_valid), 16'd1);
                chk("sweep_out", 16'(out), 16'(tbl[c-2].exp));
            end else begin
                chk("sweep_idle", 16'(out_valid), 16'd0);
            end
            if (c < 12) begin
                a = tbl[c].a; b = tbl[c].b; is_signed = tbl[c].sgn; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // backpressure: two in flight, out_ready low for 3 cycles
        a = 4'd3; b = 4'd5; is_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 4'hD; b = 4'h4; is_signed = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            chk("bp_valid", 16'(out_valid), 16'd1);
            chk("bp_hold", 16'(out), 16'h0F);
        end
        @(negedge clk);
        out_ready = 1'b1;
        chk("bp_first", 16'(out), 16'h0F);
        chk("bp_first_v", 16'(out_valid), 16'd1);
        @(negedge clk);
        chk("bp_second", 16'(out), 16'hF4);
        chk("bp_second_v", 16'(out_valid), 16'd1);
        @(negedge clk);
        chk("bp_drained", 16'(out_valid), 16'd0);

        // asynchronous reset mid-flight
        a = 4'd2; b = 4'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 4'd4;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_pre_valid", 16'(out_valid), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 16'(out_valid), 16'd0);
        chk("mr_out", 16'(out), 16'd0);
        chk("mr_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_no_stale", 16'(out_valid), 16'd0);
        end
        a = 4'd9; b = 4'd9; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_lat1", 16'(out_valid), 16'd0);
        @(negedge clk);
        chk("mr_new_valid", 16'(out_valid), 16'd1);
        chk("mr_new_out", 16'(out), 16'h51);
        repeat (2) @(negedge clk);

        // exhaustive with random in_valid / out_ready against a scoreboard
        idx = 0; cyc = 0; took = 1'b0;
        while ((idx < 512 || q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (took) in_valid = 1'b0;
            took = 1'b0;
            if (!in_valid && idx < 512 && $urandom_range(3) != 0) begin
                a = idx[3:0]; b = idx[7:4]; is_signed = idx[8]; in_valid = 1'b1;
            end
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, is_signed));
                idx++;
                took = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", 16'(out_valid), 16'd0);
                end else begin
                    front = q.pop_front();
                    chk("sb_product", 16'(out), 16'(front));
                end
            end
        end
        if (idx < 512 || q.size() > 0) begin
            n_err++;
            $display("FAIL sb_timeout: accepted %0d of 512, %0d outstanding", idx, q.size());
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // 8-bit corners: 255*255 then -128*-128, latency equals STAGES
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("w_valid", 16'(ov8[i]), 16'((c == ST8[i]) || (c == ST8[i] + 1)));
                chk("w_in_ready", 16'(ir8[i]), 16'd1);
                if (c == ST8[i])     chk("w_unsigned", o8[i], 16'hFE01);
                if (c == ST8[i] + 1) chk("w_signed", o8[i], 16'h4000);
            end
            if (c == 0) begin
                a8 = 8'hFF; b8 = 8'hFF; sgn8 = 1'b0; v8 = 1'b1;
            end else if (c == 1) begin
                a8 = 8'h80; b8 = 8'h80; sgn8 = 1'b1; v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
